// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main controller.
// A single FSM sequences fetch, decode, execute, memory and writeback over a
// shared ALU and one unified memory port, and counts retired instructions.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op                opcode field of the instruction register
//   mem_ready         memory completes the current request this cycle
//   mem_req/adr_src/mem_write      memory port control
//   ir_write/pc_write/branch/reg_write   datapath register enables
//   alu_src_a/alu_src_b/alu_op/result_src  datapath mux and ALU selects
//   imm_src           immediate format, decoded from op in every state
//   illegal_instr     high while parked on an unsupported opcode
//   instr_done        one-cycle pulse when an instruction retires
//   instret           retired-instruction counter (wraps)
module multicycle_main_fsm #(
    parameter int unsigned CNT_W     = 32,
    parameter bit          USE_READY = 1'b1,
    parameter bit          TRAP_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [2:0]       imm_src,
    output logic             illegal_instr,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
        S_JALR, S_JAL, S_ILLEGAL
    } state_t;

    state_t     state, state_nxt;
    logic       rdy;
    logic       mem_req_c, adr_src_c, mem_write_c, ir_write_c, pc_write_c;
    logic       branch_c, reg_write_c, illegal_c, done_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, result_src_c;

    // With USE_READY=0 the memory is assumed to answer in the same cycle.
    assign rdy = USE_READY ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= '0;
        else if (done_c) instret <= instret + CNT_W'(1);
    end

    always_comb begin
        state_nxt    = state;
        mem_req_c    = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        done_c       = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                // PC+4 goes straight from the ALU result into PC as IR loads.
                if (rdy) begin
                    ir_write_c   = 1'b1;
                    pc_write_c   = 1'b1;
                    src_b_c      = 2'b10;
                    result_src_c = 2'b10;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC+imm into ALUOut for branch targets.
                src_a_c = 2'b01;
                src_b_c = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    OP_JALR:           state_nxt = S_JALR;
                    OP_LUI:            state_nxt = S_LUI;
                    OP_AUIPC:          state_nxt = S_AUIPC;
                    OP_NOP: begin
                        done_c    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default:           state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                src_a_c   = 2'b10;
                src_b_c   = 2'b01;
                state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (rdy) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays up until the memory accepts the store.
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (rdy) begin
                    done_c    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a_c   = 2'b10;
                alu_op_c  = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                src_a_c   = 2'b10;
                src_b_c   = 2'b01;
                alu_op_c  = 2'b10;
                state_nxt = S_ALUWB;
            end
            S_LUI: begin
                src_b_c   = 2'b01;
                alu_op_c  = 2'b11;
                state_nxt = S_ALUWB;
            end
            S_AUIPC: begin
                src_a_c   = 2'b01;
                src_b_c   = 2'b01;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c   = 2'b10;
                alu_op_c  = 2'b01;
                branch_c  = 1'b1;
                done_c    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JALR: begin
                // Leaves rs1+imm in ALUOut so JAL can load it into PC.
                src_a_c   = 2'b10;
                src_b_c   = 2'b01;
                state_nxt = S_JAL;
            end
            S_JAL: begin
                // PC <- ALUOut (target) while the ALU forms OldPC+4 for rd.
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
                pc_write_c = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                if (!TRAP_HALT) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Control outputs are forced low while reset is held so an in-flight
    // memory request is withdrawn immediately.
    assign mem_req       = mem_req_c   & rst_n;
    assign adr_src       = adr_src_c   & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign ir_write      = ir_write_c  & rst_n;
    assign pc_write      = pc_write_c  & rst_n;
    assign branch        = branch_c    & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign illegal_instr = illegal_c   & rst_n;
    assign instr_done    = done_c      & rst_n;
    assign alu_src_a     = rst_n ? src_a_c      : 2'b00;
    assign alu_src_b     = rst_n ? src_b_c      : 2'b00;
    assign alu_op        = rst_n ? alu_op_c     : 2'b00;
    assign result_src    = rst_n ? result_src_c : 2'b00;

    always_comb begin
        imm_src = 3'b000;
        case (op)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Testbench for multicycle_main_fsm: a default instance (ready handshake,
// trap halts) and an alternate one (4-bit counter, ready ignored, trap
// returns to fetch), each compared cycle by cycle with a per-instruction
// phase model.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [6:0] op;
    logic       mem_ready;

    logic       m_mem_req, m_adr_src, m_mem_write, m_ir_write, m_pc_write;
    logic       m_branch, m_reg_write, m_illegal, m_done;
    logic [1:0] m_src_a, m_src_b, m_alu_op, m_result_src;
    logic [2:0] m_imm_src;
    logic [31:0] m_instret;

    logic       a_mem_req, a_adr_src, a_mem_write, a_ir_write, a_pc_write;
    logic       a_branch, a_reg_write, a_illegal, a_done;
    logic [1:0] a_src_a, a_src_b, a_alu_op, a_result_src;
    logic [2:0] a_imm_src;
    logic [3:0] a_instret;

    multicycle_main_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .mem_req(m_mem_req), .adr_src(m_adr_src), .mem_write(m_mem_write),
        .ir_write(m_ir_write), .pc_write(m_pc_write), .branch(m_branch),
        .reg_write(m_reg_write), .alu_src_a(m_src_a), .alu_src_b(m_src_b),
        .alu_op(m_alu_op), .result_src(m_result_src), .imm_src(m_imm_src),
        .illegal_instr(m_illegal), .instr_done(m_done), .instret(m_instret)
    );

    multicycle_main_fsm #(.CNT_W(4), .USE_READY(1'b0), .TRAP_HALT(1'b0)) alt (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .adr_src(a_adr_src), .mem_write(a_mem_write),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .branch(a_branch),
        .reg_write(a_reg_write), .alu_src_a(a_src_a), .alu_src_b(a_src_b),
        .alu_op(a_alu_op), .result_src(a_result_src), .imm_src(a_imm_src),
        .illegal_instr(a_illegal), .instr_done(a_done), .instret(a_instret)
    );

    typedef struct packed {
        logic       mem_req, adr_src, mem_write, ir_write, pc_write, branch, reg_write;
        logic [1:0] a, b, aop, rs;
        logic       ill, done;
    } ctl_t;

    logic        sel;
    ctl_t        obs;
    logic [2:0]  obs_imm;
    logic [31:0] obs_cnt;

    always_comb begin
        if (sel) begin
            obs = {a_mem_req, a_adr_src, a_mem_write, a_ir_write, a_pc_write, a_branch,
                   a_reg_write, a_src_a, a_src_b, a_alu_op, a_result_src, a_illegal, a_done};
            obs_imm = a_imm_src;
            obs_cnt = {28'd0, a_instret};
        end else begin
            obs = {m_mem_req, m_adr_src, m_mem_write, m_ir_write, m_pc_write, m_branch,
                   m_reg_write, m_src_a, m_src_b, m_alu_op, m_result_src, m_illegal, m_done};
            obs_imm = m_imm_src;
            obs_cnt = m_instret;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_cnt;
    ctl_t        exp_q[$];
    bit          mem_q[$];
    logic [6:0]  legal_ops [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
                                    7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

    function automatic logic [31:0] cnt_mask();
        return sel ? 32'h0000_000F : 32'hFFFF_FFFF;
    endfunction

    function automatic ctl_t w(input logic req, adr, mw, ir, pc, br, rw,
                               input logic [1:0] a, b, aop, rs, input logic ill, done);
        ctl_t c;
        c.mem_req = req; c.adr_src = adr; c.mem_write = mw; c.ir_write = ir;
        c.pc_write = pc; c.branch = br; c.reg_write = rw;
        c.a = a; c.b = b; c.aop = aop; c.rs = rs; c.ill = ill; c.done = done;
        return c;
    endfunction

    // Word seen while a memory phase waits: only the request itself is up.
    function automatic ctl_t stall_word(input ctl_t c);
        return w(c.mem_req, c.adr_src, c.mem_write, 0, 0, 0, 0,
                 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            7'h23:        return 3'b001;
            7'h63:        return 3'b010;
            7'h6F:        return 3'b011;
            7'h37, 7'h17: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

    function automatic void add(input ctl_t c, input bit m);
        exp_q.push_back(c);
        mem_q.push_back(m);
    endfunction

    // Phase list of one instruction, ready assumed; memory phases are marked
    // so stall cycles can be inserted in front of them.
    function automatic void build(input logic [6:0] o);
        ctl_t awb;
        awb = w(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 0,1);
        exp_q.delete();
        mem_q.delete();
        add(w(1,0,0,1,1,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0), 1);
        add(w(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,(o == 7'h00)), 0);
        case (o)
            7'h03: begin
                add(w(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0), 0);
                add(w(1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0), 1);
                add(w(0,0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 0,1), 0);
            end
            7'h23: begin
                add(w(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0), 0);
                add(w(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1), 1);
            end
            7'h33: begin add(w(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0), 0); add(awb, 0); end
            7'h13: begin add(w(0,0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0,0), 0); add(awb, 0); end
            7'h37: begin add(w(0,0,0,0,0,0,0, 2'b00,2'b01,2'b11,2'b00, 0,0), 0); add(awb, 0); end
            7'h17: begin add(w(0,0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0), 0); add(awb, 0); end
            7'h63: add(w(0,0,0,0,0,1,0, 2'b10,2'b00,2'b01,2'b00, 0,1), 0);
            7'h6F: begin add(w(0,0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0), 0); add(awb, 0); end
            7'h67: begin
                add(w(0,0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0), 0);
                add(w(0,0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, 0,0), 0);
                add(awb, 0);
            end
            7'h00: ;
            default: add(w(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0), 0);
        endcase
    endfunction

    function automatic int pick(input int v);
        return (v < 0) ? int'($urandom_range(0, 3)) : v;
    endfunction

    // Runs one instruction from FETCH; fs/ms are the stall counts for the
    // fetch and data-memory phases (-1 = random). nr drives mem_ready low
    // throughout and expects no stalls.
    task automatic exec_instr(input logic [6:0] o, input int fs, input int ms,
                              input bit nr, input string tag);
        ctl_t e;
        int   n;
        build(o);
        for (int i = 0; i < exp_q.size(); i++) begin
            n = 0;
            if (mem_q[i] && !nr) n = (i == 0) ? pick(fs) : pick(ms);
            for (int s = 0; s <= n; s++) begin
                e = (s == n) ? exp_q[i] : stall_word(exp_q[i]);
                op = o;
                if (nr)            mem_ready = 1'b0;
                else if (mem_q[i]) mem_ready = (s == n);
                else               mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL %s op=%h ph%0d ctl act=%h exp=%h", tag, o, i, obs, e);
                end
                total++;
                if (obs_imm !== exp_imm(o)) begin
                    bad++;
                    $display("FAIL %s op=%h imm_src act=%0d exp=%0d", tag, o, obs_imm, exp_imm(o));
                end
                total++;
                if (obs_cnt !== exp_cnt) begin
                    bad++;
                    $display("FAIL %s op=%h instret act=%0d exp=%0d", tag, o, obs_cnt, exp_cnt);
                end
                if (e.done) exp_cnt = (exp_cnt + 1) & cnt_mask();
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_reset();
        sel = 1'b0; op = 7'h00; mem_ready = 1'b0; rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0 || obs_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_init ctl=%h instret=%0d exp ctl=0 instret=0", obs, obs_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; exp_cnt = 0;
        exec_instr(7'h33, 0, 0, 0, "rst_pre");
        // Walk a load into MEMREAD and hold it there.
        op = 7'h03; mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (obs.mem_req !== 1'b1 || obs.adr_src !== 1'b1) begin
            bad++;
            $display("FAIL rst_memread mem_req=%b adr_src=%b exp 1 1", obs.mem_req, obs.adr_src);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== '0 || obs_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_midaccess ctl=%h instret=%0d exp ctl=0 instret=0", obs, obs_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; exp_cnt = 0;
        @(negedge clk);
        total++;
        if (obs !== w(1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0) || obs_cnt !== 32'd0) begin
            bad++;
            $display("FAIL rst_release ctl=%h instret=%0d exp fetch-wait instret=0", obs, obs_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        exec_instr(7'h33, 0, 0, 0, "rtype");
        total++;
        if (obs_cnt !== exp_cnt) begin
            bad++;
            $display("FAIL rtype_retire instret act=%0d exp=%0d", obs_cnt, exp_cnt);
        end
    endtask

    task automatic test_load_stall();
        exec_instr(7'h03, 0, 3, 0, "load_stall");
    endtask

    task automatic test_jalr();
        exec_instr(7'h67, 0, 0, 0, "jalr");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            exec_instr(legal_ops[$urandom_range(0, 9)], -1, -1, 0, "random");
    endtask

    task automatic test_illegal_halt();
        exec_instr(7'h7F, 0, 0, 0, "ill_halt");
        for (int k = 0; k < 20; k++) begin
            op = 7'($urandom); mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if (obs !== w(0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0) || obs_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL ill_hold cyc%0d ctl=%h instret=%0d exp illegal-only instret=%0d",
                         k, obs, obs_cnt, exp_cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_trap0();
        sel = 1'b1;
        apply_reset();
        exec_instr(7'h33, 0, 0, 1, "ill_pass_pre");
        exec_instr(7'h7F, 0, 0, 1, "ill_pass");
        exec_instr(7'h13, 0, 0, 1, "ill_pass_post");
    endtask

    task automatic test_wrap();
        sel = 1'b1;
        apply_reset();
        for (int k = 0; k < 15; k++)
            exec_instr(legal_ops[$urandom_range(0, 9)], 0, 0, 1, "wrap_fill");
        total++;
        if (obs_cnt !== 32'd15) begin
            bad++;
            $display("FAIL wrap_preload instret act=%0d exp=15", obs_cnt);
        end
        exec_instr(legal_ops[$urandom_range(0, 9)], 0, 0, 1, "wrap_last");
        total++;
        if (obs_cnt !== 32'd0) begin
            bad++;
            $display("FAIL wrap_zero instret act=%0d exp=0", obs_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_stall();
        test_jalr();
        test_random();
        test_illegal_halt();
        test_illegal_trap0();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
